// File: rtl/myTypes.sv
// Shared ALU opcode, stimulus FSM state type and sizing constants.
// Opcode order sets the sweep order used by the stimulus generator.
package myTypes;

  typedef enum logic [3:0] {
    adds, subs, ands, ors, xors, sle, sge, sne, srls, slls
  } aluOp;

  typedef enum logic [1:0] {IDLE, CORNER, RANDOM, DONE} stim_state_t;

  localparam int N_ALU_OPS = 10;
  localparam int N_CORNER  = 4;

  function automatic aluOp op_next(input aluOp op);
    return (op == slls) ? adds : aluOp'(op + 4'd1);
  endfunction

  function automatic logic is_shift(input aluOp op);
    return (op == srls) || (op == slls);
  endfunction

endpackage

// File: rtl/alu_lfsr.sv
// 32-bit Fibonacci LFSR (taps 32,22,2,1), updated on the falling edge.
// Load wins over enable; holds its value when neither is asserted.
module alu_lfsr #(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_enable,
  output logic [31:0] o_state
);

  logic [31:0] r_state;
  logic        w_fb;

  assign w_fb    = r_state[31] ^ r_state[21] ^ r_state[1] ^ r_state[0];
  assign o_state = r_state;

  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= SEED;
    end else if (i_enable) begin
      r_state <= {r_state[30:0], w_fb};
    end
  end

endmodule

// File: rtl/alu_stimulus.sv
// ALU stimulus generator: 160-vector corner sweep then N_RANDOM LFSR vectors.
// State moves on the falling edge so a checker can sample on the rising edge; hold freezes everything.
module alu_stimulus
  import myTypes::*;
#(
  parameter int          NBIT     = 8,
  parameter int          N_RANDOM = 64,
  parameter logic [31:0] SEED     = 32'hACE1_2468
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            hold,
  output logic [NBIT-1:0] alu_in_a,
  output logic [NBIT-1:0] alu_in_b,
  output aluOp            alu_op,
  output logic            valid,
  output logic            busy,
  output logic            done,
  output logic [15:0]     vec_count
);

  localparam int              SHW      = $clog2(NBIT);
  localparam logic [NBIT-1:0] SH_MASK  = NBIT'((1 << SHW) - 1);
  localparam logic [1:0]      LAST_IDX = 2'(N_CORNER - 1);
  localparam logic [31:0]     LAST_RND = 32'(N_RANDOM - 1);

  stim_state_t r_state, w_state_nxt;
  logic [1:0]  r_a_idx, w_a_idx_nxt;
  logic [1:0]  r_b_idx, w_b_idx_nxt;
  aluOp        r_op, w_op_nxt;
  logic [31:0] r_rnd_cnt, w_rnd_cnt_nxt;
  logic [15:0] r_vec_count, w_vec_count_nxt, w_vec_inc;
  logic        w_lfsr_load, w_lfsr_en;
  logic [31:0] w_lfsr;
  logic        w_unused_lfsr;

  alu_lfsr #(.SEED(SEED)) u_lfsr (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_load   (w_lfsr_load),
    .i_enable (w_lfsr_en),
    .o_state  (w_lfsr)
  );

  // Only the low NBIT bits of each half feed the operands.
  assign w_unused_lfsr = ^w_lfsr;

  function automatic logic [NBIT-1:0] corner_val(input logic [1:0] idx);
    case (idx)
      2'd0:    corner_val = '0;
      2'd1:    corner_val = NBIT'(1);
      2'd2:    corner_val = '1;
      default: corner_val = {1'b1, {(NBIT-1){1'b0}}};
    endcase
  endfunction

  // vec_count counts vectors already consumed, so it reads 0 while vector 0 is shown.
  assign w_vec_inc = (r_vec_count == 16'hFFFF) ? r_vec_count : r_vec_count + 16'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_a_idx_nxt     = r_a_idx;
    w_b_idx_nxt     = r_b_idx;
    w_op_nxt        = r_op;
    w_rnd_cnt_nxt   = r_rnd_cnt;
    w_vec_count_nxt = r_vec_count;
    w_lfsr_load     = 1'b0;
    w_lfsr_en       = 1'b0;
    if (!hold) begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_state_nxt     = CORNER;
            w_a_idx_nxt     = '0;
            w_b_idx_nxt     = '0;
            w_op_nxt        = adds;
            w_rnd_cnt_nxt   = '0;
            w_vec_count_nxt = '0;
            w_lfsr_load     = 1'b1;
          end
        end
        CORNER: begin
          w_vec_count_nxt = w_vec_inc;
          w_op_nxt        = op_next(r_op);
          if (r_op == slls) begin
            w_b_idx_nxt = r_b_idx + 2'd1;
            if (r_b_idx == LAST_IDX) begin
              w_a_idx_nxt = r_a_idx + 2'd1;
              if (r_a_idx == LAST_IDX) begin
                w_state_nxt = (N_RANDOM == 0) ? DONE : RANDOM;
              end
            end
          end
        end
        RANDOM: begin
          w_vec_count_nxt = w_vec_inc;
          w_op_nxt        = op_next(r_op);
          w_rnd_cnt_nxt   = r_rnd_cnt + 32'd1;
          w_lfsr_en       = 1'b1;
          if (r_rnd_cnt == LAST_RND) begin
            w_state_nxt = DONE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a_idx     <= '0;
      r_b_idx     <= '0;
      r_op        <= adds;
      r_rnd_cnt   <= '0;
      r_vec_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_a_idx     <= w_a_idx_nxt;
      r_b_idx     <= w_b_idx_nxt;
      r_op        <= w_op_nxt;
      r_rnd_cnt   <= w_rnd_cnt_nxt;
      r_vec_count <= w_vec_count_nxt;
    end
  end

  always_comb begin
    alu_in_a = '0;
    alu_in_b = '0;
    alu_op   = adds;
    case (r_state)
      CORNER: begin
        alu_in_a = corner_val(r_a_idx);
        alu_in_b = corner_val(r_b_idx);
        alu_op   = r_op;
      end
      RANDOM: begin
        alu_in_a = w_lfsr[NBIT-1:0];
        alu_in_b = is_shift(r_op) ? (w_lfsr[16 +: NBIT] & SH_MASK) : w_lfsr[16 +: NBIT];
        alu_op   = r_op;
      end
      default: begin
        alu_in_a = '0;
      end
    endcase
  end

  assign valid     = (r_state == CORNER) || (r_state == RANDOM);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign vec_count = r_vec_count;

endmodule

// File: tb/tb_alu_stimulus.sv
// Scoreboard bench for alu_stimulus: stimulus pushes expected vectors, a rising-edge monitor pops and compares.
module tb_alu_stimulus;
  import myTypes::*;

  localparam int          NBIT   = 8;
  localparam int          NRND   = 64;
  localparam int          NCORN  = 160;
  localparam int          NTOT   = NCORN + NRND;
  localparam logic [31:0] SEED_V = 32'hACE1_2468;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    aluOp       op;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            hold = 1'b0;
  logic [NBIT-1:0] alu_in_a, alu_in_b;
  aluOp            alu_op;
  logic            valid, busy, done;
  logic [15:0]     vec_count;

  alu_stimulus #(.NBIT(NBIT), .N_RANDOM(NRND), .SEED(SEED_V)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .hold      (hold),
    .alu_in_a  (alu_in_a),
    .alu_in_b  (alu_in_b),
    .alu_op    (alu_op),
    .valid     (valid),
    .busy      (busy),
    .done      (done),
    .vec_count (vec_count)
  );

  always #5 clk = ~clk;

  vec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_popped = 0;
  int   valid_cycles = 0;
  int   busy_cycles = 0;
  int   done_pulses = 0;
  logic prev_done = 1'b0;

  // Hand-computed vectors: sweep start, first B step, sweep end, first two random.
  int   hand_idx [5] = '{0, 10, 159, 160, 161};
  vec_t hand_vec [5] = '{
    '{a: 8'h00, b: 8'h00, op: adds},
    '{a: 8'h00, b: 8'h01, op: adds},
    '{a: 8'h80, b: 8'h80, op: slls},
    '{a: 8'h68, b: 8'hE1, op: adds},
    '{a: 8'hD0, b: 8'hC2, op: subs}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_model(input logic [31:0] s);
    logic fb;
    fb = s[32-1] ^ s[22-1] ^ s[2-1] ^ s[1-1];
    return {s[30:0], fb};
  endfunction

  task automatic push_sequence();
    logic [7:0]  cv [4];
    logic [31:0] s;
    vec_t        v;
    cv = '{8'h00, 8'h01, 8'hFF, 8'h80};
    for (int ai = 0; ai < 4; ai++)
      for (int bi = 0; bi < 4; bi++)
        for (int oi = 0; oi < 10; oi++) begin
          v.a  = cv[ai];
          v.b  = cv[bi];
          v.op = aluOp'(oi);
          exp_q.push_back(v);
        end
    s = SEED_V;
    for (int r = 0; r < NRND; r++) begin
      v.a  = s[7:0];
      v.b  = s[23:16];
      v.op = aluOp'(r % 10);
      if (r % 10 >= 8) v.b = v.b & 8'h07;
      exp_q.push_back(v);
      s = lfsr_model(s);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      if (busy) busy_cycles++;
      if (prev_done) check("busy_after_done", 32'(busy), 32'd0);
      prev_done = done;
      if (done) begin
        done_pulses++;
        check("done_vec_count", 32'(vec_count), 32'(NTOT));
        check("done_valid", 32'(valid), 32'd0);
        check("done_queue_left", 32'(exp_q.size()), 32'd0);
      end
      if (valid) begin
        valid_cycles++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_vector: got a=%0h b=%0h op=%0d with empty queue", alu_in_a, alu_in_b, alu_op);
        end else begin
          check("vec_a", 32'(alu_in_a), 32'(exp_q[0].a));
          check("vec_b", 32'(alu_in_b), 32'(exp_q[0].b));
          check("vec_op", 32'(alu_op), 32'(exp_q[0].op));
          check("vec_count", 32'(vec_count), 32'(n_popped));
          check("vec_busy", 32'(busy), 32'd1);
          if (n_popped >= NCORN && is_shift(alu_op))
            check("rand_shift_b_lt8", 32'(alu_in_b < 8'd8), 32'd1);
          for (int i = 0; i < 5; i++)
            if (n_popped == hand_idx[i]) begin
              check("hand_a", 32'(alu_in_a), 32'(hand_vec[i].a));
              check("hand_b", 32'(alu_in_b), 32'(hand_vec[i].b));
              check("hand_op", 32'(alu_op), 32'(hand_vec[i].op));
            end
          if (!hold) begin
            void'(exp_q.pop_front());
            n_popped++;
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_popped(input int n);
    int k = 0;
    while (n_popped < n && k < 2000) begin
      step();
      k++;
    end
    if (n_popped < n) begin
      checks++;
      failures++;
      $display("FAIL wait_vector_timeout: got %0d vectors required %0d", n_popped, n);
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 2000) begin
      step();
      k++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL wait_done_timeout: done=%0b vectors=%0d", done, n_popped);
    end
  endtask

  task automatic clear_run();
    exp_q.delete();
    n_popped     = 0;
    valid_cycles = 0;
    busy_cycles  = 0;
    done_pulses  = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_a"}, 32'(alu_in_a), 32'd0);
    check({tag, "_b"}, 32'(alu_in_b), 32'd0);
    check({tag, "_op"}, 32'(alu_op), 32'(adds));
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic run_seq(input int hold_at, input int restart_at, input int exp_busy, input int exp_valid);
    clear_run();
    push_sequence();
    pulse_start();
    if (restart_at >= 0) begin
      wait_popped(restart_at);
      pulse_start();
    end
    if (hold_at >= 0) begin
      wait_popped(hold_at);
      hold = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      hold = 1'b0;
    end
    wait_done();
    pulse_start();
    repeat (3) step();
    check("run_done_pulses", 32'(done_pulses), 32'd1);
    check("run_valid_cycles", 32'(valid_cycles), 32'(exp_valid));
    check("run_busy_cycles", 32'(busy_cycles), 32'(exp_busy));
    check("run_vectors", 32'(n_popped), 32'(NTOT));
    check("idle_vec_count", 32'(vec_count), 32'(NTOT));
    check_idle("post_run");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) step();
    check_idle("reset");
    check("reset_vec_count", 32'(vec_count), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // Hold asserted with start in IDLE must not launch a sequence.
    hold  = 1'b1;
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    hold  = 1'b0;
    step();
    check("hold_blocks_start", 32'(busy), 32'd0);

    run_seq(-1, 30, NTOT + 1, NTOT);
    run_seq(50, -1, NTOT + 6, NTOT + 5);

    clear_run();
    push_sequence();
    pulse_start();
    wait_popped(100);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("abort");
    check("abort_vec_count", 32'(vec_count), 32'd0);
    check("abort_no_done", 32'(done_pulses), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("abort_stays_idle", 32'(busy), 32'd0);
    run_seq(-1, -1, NTOT + 1, NTOT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
